// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: op codes, FSM states, flag bit positions.
package exec_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // out_flags = {Z,N,V,C}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_seq.sv
// Shift-add multiplier, one multiplier bit per step; done flags the final step.
module mul_seq #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CW = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] mcand, mplier, acc;
    logic [CW-1:0]     cnt;

    // Latch operands on start, then accumulate the shifted multiplicand per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    assign done    = (cnt == CW'(DATA_W - 1));
    assign product = acc;

endmodule

// File: rtl/execute_stage_mc.sv
// Execute stage: forwarding muxes, single-cycle ALU, iterative multiplier
// sequenced by a small FSM, and the EX/MEM output register.
module execute_stage_mc
    import exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wr,
    input  logic              xm_wr,
    input  logic [REG_AW-1:0] xm_rd,
    input  logic [DATA_W-1:0] xm_data,
    input  logic              mw_wr,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic [DATA_W-1:0] mw_data,
    input  logic              hold,
    input  logic              flush,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wr,
    output logic [3:0]        out_flags
);

    localparam int SHW = $clog2(DATA_W);

    state_t            state, state_nx;
    logic [DATA_W-1:0] op_a, op_b, alu_res, mul_product;
    logic [DATA_W:0]   sum, diff;
    logic [3:0]        alu_flags, mul_flags;
    logic              is_mul, alu_go, mul_start, mul_step, mul_done;
    logic [REG_AW-1:0] mul_rd;
    logic              mul_wr;

    // Forwarding: EX/MEM wins over MEM/WB, which wins over the register file.
    always_comb begin
        op_a = in_a;
        op_b = in_b;
        if (xm_wr && xm_rd == in_rs)      op_a = xm_data;
        else if (mw_wr && mw_rd == in_rs) op_a = mw_data;
        if (xm_wr && xm_rd == in_rt)      op_b = xm_data;
        else if (mw_wr && mw_rd == in_rt) op_b = mw_data;
    end

    // Single-cycle ALU and its flags; MUL is handled by mul_seq.
    always_comb begin
        sum       = {1'b0, op_a} + {1'b0, op_b};
        diff      = {1'b0, op_a} - {1'b0, op_b};
        alu_res   = '0;
        alu_flags = '0;
        case (in_op)
            OP_ADD: begin
                alu_res           = sum[DATA_W-1:0];
                alu_flags[FLAG_C] = sum[DATA_W];
                alu_flags[FLAG_V] = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                                    (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res           = diff[DATA_W-1:0];
                alu_flags[FLAG_C] = ~diff[DATA_W];
                alu_flags[FLAG_V] = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                                    (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << op_b[SHW-1:0];
            OP_SRL:  alu_res = op_a >> op_b[SHW-1:0];
            OP_PASS: alu_res = op_b;
            default: alu_res = '0;
        endcase
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_N] = alu_res[DATA_W-1];
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_product == '0);
        mul_flags[FLAG_N] = mul_product[DATA_W-1];
    end

    assign is_mul    = in_valid && in_op == OP_MUL;
    assign alu_go    = state == ST_IDLE && in_valid && !is_mul && !hold && !flush;
    assign mul_start = state == ST_IDLE && is_mul && !hold && !flush;
    assign mul_step  = state == ST_MUL && !hold && !flush;
    // flush overrides hold; reset forces stall low.
    assign stall     = !rst && !flush &&
                       (hold || state == ST_MUL || (state == ST_IDLE && is_mul));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // FSM next state: flush aborts, hold freezes.
    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = ST_IDLE;
        end else if (!hold) begin
            case (state)
                ST_IDLE: if (is_mul)   state_nx = ST_MUL;
                ST_MUL:  if (mul_done) state_nx = ST_DONE;
                ST_DONE: state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Destination of the in-flight multiply, captured at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_rd <= '0;
            mul_wr <= 1'b0;
        end else if (mul_start) begin
            mul_rd <= in_rd;
            mul_wr <= in_wr;
        end
    end

    // EX/MEM register: product in DONE, ALU result on a latency-1 issue, else a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_wr     <= 1'b0;
            out_flags  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_wr    <= 1'b0;
        end else if (!hold) begin
            if (state == ST_DONE) begin
                out_valid  <= 1'b1;
                out_result <= mul_product;
                out_rd     <= mul_rd;
                out_wr     <= mul_wr;
                out_flags  <= mul_flags;
            end else if (alu_go) begin
                out_valid  <= 1'b1;
                out_result <= alu_res;
                out_rd     <= in_rd;
                out_wr     <= in_wr;
                out_flags  <= alu_flags;
            end else begin
                out_valid <= 1'b0;
                out_wr    <= 1'b0;
            end
        end
    end

    mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .step    (mul_step),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc with hand-computed expectations.
module tb_execute_stage_mc;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic [2:0]  in_op = 0;
    logic [15:0] in_a = 0, in_b = 0;
    logic [2:0]  in_rs = 0, in_rt = 0, in_rd = 0;
    logic        in_wr = 0;
    logic        xm_wr = 0, mw_wr = 0;
    logic [2:0]  xm_rd = 0, mw_rd = 0;
    logic [15:0] xm_data = 0, mw_data = 0;
    logic        hold = 0, flush = 0;
    logic        stall, out_valid, out_wr;
    logic [15:0] out_result;
    logic [2:0]  out_rd;
    logic [3:0]  out_flags;

    int total = 0;
    int bad = 0;

    execute_stage_mc #(.DATA_W(16), .REG_AW(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_wr(in_wr),
        .xm_wr(xm_wr), .xm_rd(xm_rd), .xm_data(xm_data),
        .mw_wr(mw_wr), .mw_rd(mw_rd), .mw_data(mw_data),
        .hold(hold), .flush(flush), .stall(stall),
        .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
        .out_wr(out_wr), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] rd);
        in_valid = 1; in_op = op; in_a = a; in_b = b;
        in_rs = 3'd1; in_rt = 3'd2; in_rd = rd; in_wr = 1;
        xm_wr = 0; mw_wr = 0;
    endtask

    // op, a, b, result, flags {Z,N,V,C}
    logic [2:0]  v_op  [11] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b011,
                                3'b100, 3'b101, 3'b111, 3'b001, 3'b000};
    logic [15:0] v_a   [11] = '{16'h7FFF, 16'h0005, 16'h0003, 16'hFFFF, 16'hF0F0, 16'hF0F0,
                                16'h0001, 16'h8000, 16'h1234, 16'h8000, 16'h8000};
    logic [15:0] v_b   [11] = '{16'h0001, 16'h0005, 16'h0005, 16'h0001, 16'hFF00, 16'hFF00,
                                16'h0014, 16'h000F, 16'h8001, 16'h0001, 16'h8000};
    logic [15:0] v_res [11] = '{16'h8000, 16'h0000, 16'hFFFE, 16'h0000, 16'hF000, 16'h0FF0,
                                16'h0010, 16'h0001, 16'h8001, 16'h7FFF, 16'h0000};
    logic [3:0]  v_flg [11] = '{4'b0110, 4'b1001, 4'b0100, 4'b1001, 4'b0100, 4'b0000,
                                4'b0000, 4'b0000, 4'b0100, 4'b0011, 4'b1011};

    initial begin
        int stall_cnt;
        int edges;
        int seen;

        // reset state, asynchronous
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_flags", out_flags, 0);
        chk("rst_wr", out_wr, 0);
        chk("rst_stall", stall, 0);
        tick();
        rst = 0;
        tick();

        // ALU vector table, latency 1
        for (int i = 0; i < 11; i++) begin
            issue(v_op[i], v_a[i], v_b[i], 3'd4);
            #1 chk($sformatf("alu%0d_stall", i), stall, 0);
            tick();
            chk($sformatf("alu%0d_res", i), out_result, v_res[i]);
            chk($sformatf("alu%0d_flg", i), out_flags, v_flg[i]);
            chk($sformatf("alu%0d_vld", i), out_valid, 1);
        end
        chk("alu_rd", out_rd, 4);
        chk("alu_wr", out_wr, 1);

        // forwarding priority
        issue(3'b000, 16'h0033, 16'h0000, 3'd1);
        in_rs = 3; in_rt = 5;
        xm_wr = 1; xm_rd = 3; xm_data = 16'h0011;
        mw_wr = 1; mw_rd = 3; mw_data = 16'h0022;
        tick();
        chk("fwd_xm", out_result, 16'h0011);
        xm_wr = 0;
        tick();
        chk("fwd_mw", out_result, 16'h0022);
        mw_wr = 0;
        tick();
        chk("fwd_none", out_result, 16'h0033);
        in_op = 3'b111; in_rt = 3; in_b = 16'h0044;
        mw_wr = 1; xm_wr = 1; xm_rd = 6;
        tick();
        chk("fwd_b_mw", out_result, 16'h0022);
        xm_wr = 0; mw_wr = 0;

        // SUB equal then hold for three cycles
        issue(3'b001, 16'h0005, 16'h0005, 3'd3);
        tick();
        chk("sub_eq_flg", out_flags, 4'b1001);
        issue(3'b000, 16'h0001, 16'h0001, 3'd2);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("hold%0d_stall", i), stall, 1);
            tick();
            chk($sformatf("hold%0d_res", i), out_result, 16'h0000);
            chk($sformatf("hold%0d_flg", i), out_flags, 4'b1001);
            chk($sformatf("hold%0d_vld", i), out_valid, 1);
            chk($sformatf("hold%0d_rd", i), out_rd, 3);
        end
        hold = 0;
        tick();
        chk("hold_release", out_result, 16'h0002);

        // flush beats hold
        hold = 1; flush = 1;
        tick();
        chk("flush_hold_vld", out_valid, 0);
        chk("flush_hold_wr", out_wr, 0);
        hold = 0; flush = 0; in_valid = 0;
        tick();
        chk("bubble_vld", out_valid, 0);

        // MUL 0x12 * 0x34
        issue(3'b110, 16'h0012, 16'h0034, 3'd5);
        stall_cnt = 0; edges = 0; seen = 0;
        while (edges < 40 && !seen) begin
            #1 if (stall) stall_cnt++;
            tick();
            edges++;
            if (out_valid) begin
                seen = 1;
                in_valid = 0;
            end
        end
        chk("mul_seen", seen, 1);
        chk("mul_edges", edges, 18);
        chk("mul_stall_cnt", stall_cnt, 17);
        chk("mul_res", out_result, 16'h03A8);
        chk("mul_flg", out_flags, 4'b0000);
        chk("mul_rd", out_rd, 5);
        tick();
        chk("mul_one_cycle", out_valid, 0);

        // flush on the 5th MUL cycle
        issue(3'b110, 16'h0003, 16'h0003, 3'd6);
        for (int i = 0; i < 5; i++) tick();
        chk("mflush_stall_before", stall, 1);
        flush = 1; in_valid = 0;
        tick();
        flush = 0;
        #1 chk("mflush_stall_after", stall, 0);
        chk("mflush_vld", out_valid, 0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mflush_no_result", seen, 0);

        // reset mid-MUL, after a valid nonzero output
        issue(3'b000, 16'h7FFF, 16'h0001, 3'd7);
        tick();
        issue(3'b110, 16'h0012, 16'h0034, 3'd5);
        tick();
        tick();
        chk("mrst_stall_before", stall, 1);
        chk("mrst_res_before", out_result, 16'h8000);
        #2 rst = 1;
        #1;
        chk("mrst_res", out_result, 0);
        chk("mrst_flg", out_flags, 0);
        chk("mrst_rd", out_rd, 0);
        chk("mrst_vld", out_valid, 0);
        chk("mrst_stall", stall, 0);
        tick();
        chk("mrst_stall_held", stall, 0);
        rst = 0;
        in_valid = 0;
        tick();
        chk("mrst_idle_stall", stall, 0);
        issue(3'b000, 16'h0001, 16'h0001, 3'd1);
        tick();
        chk("mrst_idle_add", out_result, 16'h0002);
        chk("mrst_idle_vld", out_valid, 1);
        in_valid = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
